// File: rtl/dff_reg_arbiter.sv
// Round-robin arbiter that shares one WIDTH-bit register between 4 requesters.
// Owners keep their grant while holding req; MAX_HOLD forces rotation when others wait.
module dff_reg_arbiter #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [3:0]         req,
  input  logic [3:0]         we,
  input  logic [4*WIDTH-1:0] wdata,
  output logic [3:0]         gnt,
  output logic               busy,
  output logic [WIDTH-1:0]   q,
  output logic [WIDTH-1:0]   q_bar
);

  localparam int unsigned HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           r_state;
  logic [1:0]       r_ptr;
  logic [1:0]       r_owner;
  logic [HW-1:0]    r_hold;
  logic [3:0]       r_gnt;
  logic             r_busy;
  logic [WIDTH-1:0] r_q;

  logic [3:0]       w_mask;
  logic [1:0]       w_idx;
  logic [1:0]       w_next;
  logic             w_found;
  logic             w_wr;
  logic [WIDTH-1:0] w_wdata;

  // The current owner is excluded so handover always picks a different requester.
  always_comb begin
    w_mask  = (r_state == GRANT) ? (req & ~r_gnt) : req;
    w_found = 1'b0;
    w_next  = '0;
    w_idx   = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      w_idx = r_ptr + 2'(i);
      if (!w_found && w_mask[w_idx]) begin
        w_found = 1'b1;
        w_next  = w_idx;
      end
    end
  end

  assign w_wr    = (r_state == GRANT) && req[r_owner] && we[r_owner];
  assign w_wdata = wdata[r_owner*WIDTH +: WIDTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_hold  <= '0;
      r_gnt   <= '0;
      r_busy  <= 1'b0;
      r_q     <= '0;
    end else begin
      if (w_wr) r_q <= w_wdata;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state <= GRANT;
            r_gnt   <= 4'(1) << w_next;
            r_owner <= w_next;
            r_ptr   <= w_next + 2'd1;
            r_hold  <= '0;
            r_busy  <= 1'b1;
          end else begin
            r_gnt  <= '0;
            r_busy <= 1'b0;
          end
        end
        GRANT: begin
          if (!req[r_owner] || (r_hold == HOLD_LAST && w_found)) begin
            if (w_found) begin
              r_gnt   <= 4'(1) << w_next;
              r_owner <= w_next;
              r_ptr   <= w_next + 2'd1;
              r_hold  <= '0;
            end else begin
              r_state <= IDLE;
              r_gnt   <= '0;
              r_busy  <= 1'b0;
              r_hold  <= '0;
            end
          end else if (r_hold != HOLD_LAST) begin
            r_hold <= r_hold + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt   = r_gnt;
  assign busy  = r_busy;
  assign q     = r_q;
  assign q_bar = ~r_q;

endmodule

// File: tb/tb_dff_reg_arbiter.sv
// Directed bench for dff_reg_arbiter: reset, writes, rotation, hold-limit preemption.
module tb_dff_reg_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  req = '0;
  logic [3:0]  we = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  gnt;
  logic        busy;
  logic [7:0]  q;
  logic [7:0]  q_bar;

  int n_cmp  = 0;
  int n_fail = 0;

  dff_reg_arbiter #(.WIDTH(8), .MAX_HOLD(4)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .we(we), .wdata(wdata),
    .gnt(gnt), .busy(busy), .q(q), .q_bar(q_bar)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; req = '0; we = '0; wdata = '0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt0 got=%b exp=0000", gnt); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy0 got=%b exp=0", busy); end
    tick();
    reset_n = 1'b1;
    req = 4'b0010;
    tick();
    we = 4'b0010; wdata[15:8] = 8'h77;
    tick();
    n_cmp++; if (q !== 8'h77) begin n_fail++; $display("FAIL pre_reset_q got=%h exp=77", q); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (q !== 8'h00) begin n_fail++; $display("FAIL reset_q got=%h exp=00", q); end
    n_cmp++; if (q_bar !== 8'hFF) begin n_fail++; $display("FAIL reset_qbar got=%h exp=FF", q_bar); end
    req = '0; we = '0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_single_write();
    do_reset();
    req = 4'b0100;
    tick();
    n_cmp++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL sw_gnt got=%b exp=0100", gnt); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL sw_busy got=%b exp=1", busy); end
    we = 4'b0100; wdata[23:16] = 8'hA5;
    tick();
    n_cmp++; if (q !== 8'hA5) begin n_fail++; $display("FAIL sw_q got=%h exp=A5", q); end
    n_cmp++; if (q_bar !== 8'h5A) begin n_fail++; $display("FAIL sw_qbar got=%h exp=5A", q_bar); end
    we = '0; req = '0;
    tick();
    n_cmp++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL sw_rel_gnt got=%b exp=0000", gnt); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sw_rel_busy got=%b exp=0", busy); end
    n_cmp++; if (q !== 8'hA5) begin n_fail++; $display("FAIL sw_hold_q got=%h exp=A5", q); end
  endtask

  task automatic test_round_robin();
    logic [3:0] reqs [5];
    logic [3:0] exps [5];
    reqs = '{4'b1111, 4'b1110, 4'b1101, 4'b1011, 4'b0111};
    exps = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      req = reqs[i];
      tick();
      n_cmp++; if (gnt !== exps[i]) begin n_fail++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", i, gnt, exps[i]); end
      n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rr_busy[%0d] got=%b exp=1", i, busy); end
    end
    req = '0;
    tick();
    n_cmp++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL rr_idle got=%b exp=0000", gnt); end
  endtask

  task automatic test_preempt();
    do_reset();
    req = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        we = 4'b1001; wdata[7:0] = 8'h5E; wdata[31:24] = 8'hEE;
      end
      tick();
      n_cmp++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL pre_g0[%0d] got=%b exp=0001", i, gnt); end
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      we = '0;
      n_cmp++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL pre_g3[%0d] got=%b exp=1000", i, gnt); end
      if (i == 0) begin
        n_cmp++; if (q !== 8'h5E) begin n_fail++; $display("FAIL pre_last_wr got=%h exp=5E", q); end
      end
    end
    tick();
    n_cmp++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL pre_back0 got=%b exp=0001", gnt); end
    req = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_cmp++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL sole_g0[%0d] got=%b exp=0001", i, gnt); end
    end
    req = '0;
    tick();
  endtask

  task automatic test_ignored_writes();
    do_reset();
    req = 4'b0010;
    tick();
    n_cmp++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL ig_gnt got=%b exp=0010", gnt); end
    we = 4'b0010; wdata[15:8] = 8'h11;
    tick();
    n_cmp++; if (q !== 8'h11) begin n_fail++; $display("FAIL ig_own_wr got=%h exp=11", q); end
    we = 4'b0001; wdata[7:0] = 8'h3C;
    tick();
    n_cmp++; if (q !== 8'h11) begin n_fail++; $display("FAIL ig_nonowner got=%h exp=11", q); end
    req = '0; we = 4'b0010; wdata[15:8] = 8'h99;
    tick();
    n_cmp++; if (q !== 8'h11) begin n_fail++; $display("FAIL ig_noreq got=%h exp=11", q); end
    n_cmp++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL ig_rel got=%b exp=0000", gnt); end
    we = '0;
  endtask

  task automatic test_async_reset_grant();
    do_reset();
    req = 4'b0100;
    tick();
    n_cmp++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL ar_gnt got=%b exp=0100", gnt); end
    we = 4'b0100; wdata[23:16] = 8'hFF;
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL ar_gnt0 got=%b exp=0000", gnt); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ar_busy got=%b exp=0", busy); end
    tick();
    n_cmp++; if (q !== 8'h00) begin n_fail++; $display("FAIL ar_q got=%h exp=00", q); end
    we = '0; req = 4'b1001;
    reset_n = 1'b1;
    tick();
    n_cmp++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL ar_first got=%b exp=0001", gnt); end
    req = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_preempt();
    test_ignored_writes();
    test_async_reset_grant();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
